// File: rtl/fir_seq_ctrl.sv
// Sequencer for a single-MAC time-multiplexed FIR: zero-fills the sample buffer,
// accepts one sample at a time, walks every tap through the shared MAC and hands off the result.
module fir_seq_ctrl #(
   parameter int WIDTH  = 10,
   parameter int N_TAPS = 465,
   parameter int ADDR_W = 9,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              samp_we,
   output logic              samp_wsel,
   output logic [ADDR_W-1:0] samp_waddr,
   output logic [ADDR_W-1:0] samp_raddr,
   output logic [ADDR_W-1:0] coef_raddr,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_TAPS - 1);
   localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(RD_LAT - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;     // init index, tap index k, or drain count
   logic [ADDR_W-1:0]   wp_q, wp_d;
   logic [ADDR_W-1:0]   sra_q, sra_d;     // sample read address, counts down from base
   logic [RD_LAT-1:0]   iss_q, iss_d;
   logic [RD_LAT-1:0]   first_q, first_d;

   logic                issue;
   logic                issue_first;
   logic                in_ready_c;
   logic                we_c;
   logic                wsel_c;
   logic [ADDR_W-1:0]   waddr_c;
   logic [ADDR_W-1:0]   raddr_c;
   logic [ADDR_W-1:0]   craddr_c;
   logic                ov_c;

   // Handshakes: a sample transfers in any cycle where in_valid && in_ready; a result
   // transfers in any cycle where out_valid && out_ready. Neither side's valid waits on ready.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wp_d        = wp_q;
      sra_d       = sra_q;
      issue       = 1'b0;
      issue_first = 1'b0;
      in_ready_c  = 1'b0;
      we_c        = 1'b0;
      wsel_c      = 1'b1;
      waddr_c     = '0;
      raddr_c     = '0;
      craddr_c    = '0;
      ov_c        = 1'b0;

      case (state_q)
         S_INIT: begin
            we_c    = 1'b1;
            waddr_c = cnt_q;
            if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_IDLE: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
               we_c    = 1'b1;
               wsel_c  = 1'b0;
               waddr_c = wp_q;
               sra_d   = wp_q;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            issue       = 1'b1;
            issue_first = (cnt_q == '0);
            raddr_c     = sra_q;
            craddr_c    = cnt_q;
            // Oldest samples sit just below base, wrapping through the top of the buffer.
            sra_d       = (sra_q == '0) ? LAST_ADDR : sra_q - 1'b1;
            if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DRAIN: begin
            if (cnt_q == LAST_DRAIN) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE: begin
            ov_c = 1'b1;
            if (out_ready) begin
               wp_d    = (wp_q == LAST_ADDR) ? '0 : wp_q + 1'b1;
               state_d = S_IDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = S_INIT;
         end
      endcase
   end

   // Issue strobes ride a RD_LAT-deep delay line so acc_en lines up with the product.
   always_comb begin
      iss_d    = '0;
      first_d  = '0;
      iss_d[0]   = issue;
      first_d[0] = issue_first;
      for (int i = 1; i < RD_LAT; i++) begin
         iss_d[i]   = iss_q[i-1];
         first_d[i] = first_q[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         wp_q    <= '0;
         sra_q   <= '0;
         iss_q   <= '0;
         first_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wp_q    <= wp_d;
         sra_q   <= sra_d;
         iss_q   <= iss_d;
         first_q <= first_d;
      end
   end

   // State-decoded outputs are forced idle while reset is held so nothing reaches the datapath.
   assign in_ready   = reset_n & in_ready_c;
   assign samp_we    = reset_n & we_c;
   assign samp_wsel  = ~reset_n | wsel_c;
   assign samp_waddr = reset_n ? waddr_c  : '0;
   assign samp_raddr = reset_n ? raddr_c  : '0;
   assign coef_raddr = reset_n ? craddr_c : '0;
   assign out_valid  = reset_n & ov_c;
   assign acc_en     = reset_n & iss_q[RD_LAT-1];
   assign acc_clr    = reset_n & first_q[RD_LAT-1];
   assign dbg_state  = state_q;

   a_params: assert property (@(posedge clock)
      (WIDTH > 0) && (RD_LAT >= 1) && (RD_LAT <= 4) && ((1 << ADDR_W) >= N_TAPS));

   a_we_scope: assert property (@(posedge clock) disable iff (!reset_n)
      samp_we |-> ((state_q == S_INIT) || ((state_q == S_IDLE) && in_valid)));

   a_ov_hold: assert property (@(posedge clock) disable iff (!reset_n)
      (out_valid && !out_ready) |=> out_valid);

   a_clr_en: assert property (@(posedge clock) disable iff (!reset_n)
      acc_clr |-> acc_en);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized bench for fir_seq_ctrl: a tap-timing model checks every control output each
// cycle, and a behavioural datapath checks each result against a direct convolution.
module tb_fir_seq_ctrl;

   localparam int WIDTH  = 10;
   localparam int N_TAPS = 5;
   localparam int ADDR_W = 3;
   localparam int RD_LAT = 2;
   localparam int N_OUT_A = 30;
   localparam int N_OUT_B = 60;
   localparam int GUARD   = 20000;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  samp_in = '0;
   logic              in_ready, samp_we, samp_wsel, acc_clr, acc_en, out_valid;
   logic [ADDR_W-1:0] samp_waddr, samp_raddr, coef_raddr;
   logic [2:0]        dbg_state;

   always #5 clock = ~clock;

   fir_seq_ctrl #(
      .WIDTH (WIDTH),
      .N_TAPS(N_TAPS),
      .ADDR_W(ADDR_W),
      .RD_LAT(RD_LAT)
   ) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .samp_we   (samp_we),
      .samp_wsel (samp_wsel),
      .samp_waddr(samp_waddr),
      .samp_raddr(samp_raddr),
      .coef_raddr(coef_raddr),
      .acc_clr   (acc_clr),
      .acc_en    (acc_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dbg_state (dbg_state)
   );

   // Behavioural datapath: sample RAM, coefficient ROM, RD_LAT-deep product pipe, MAC.
   logic [WIDTH-1:0] ram  [2**ADDR_W];
   logic [31:0]      rom  [2**ADDR_W];
   logic [31:0]      pipe [RD_LAT];
   logic [31:0]      acc_m = '0;

   always @(posedge clock) begin
      if (samp_we) ram[samp_waddr] <= samp_wsel ? '0 : samp_in;
      pipe[0] <= 32'(ram[samp_raddr]) * rom[coef_raddr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      if (acc_en) acc_m <= acc_clr ? pipe[RD_LAT-1] : acc_m + pipe[RD_LAT-1];
   end

   // Scoreboard and reference state.
   logic [31:0] exp_q[$];
   int          hist[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          guard = 0;
   int          init_idx, busy, acc_cyc, wp_m, base_m, n_out, stall_cnt, stall_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      init_idx  = 0;
      busy      = 0;
      acc_cyc   = 0;
      wp_m      = 0;
      base_m    = 0;
      stall_cnt = 0;
      hist.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_in_ready",  32'(in_ready),   32'd0);
      chk("rst_samp_we",   32'(samp_we),    32'd0);
      chk("rst_samp_wsel", 32'(samp_wsel),  32'd1);
      chk("rst_waddr",     32'(samp_waddr), 32'd0);
      chk("rst_raddr",     32'(samp_raddr), 32'd0);
      chk("rst_craddr",    32'(coef_raddr), 32'd0);
      chk("rst_acc_en",    32'(acc_en),     32'd0);
      chk("rst_acc_clr",   32'(acc_clr),    32'd0);
      chk("rst_out_valid", 32'(out_valid),  32'd0);
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic step();
      int   d, k, e_waddr;
      logic e_ir, e_we, e_wsel, e_iss, e_en, e_clr, e_ov;
      logic [31:0] y;
      @(negedge clock);
      d    = cyc - acc_cyc;
      e_ov = (busy != 0) && (d >= N_TAPS + RD_LAT + 1);
      if (e_ov && n_out == 3 && stall_done == 0) begin
         stall_cnt  = 10;
         stall_done = 1;
      end
      in_valid = ($urandom_range(0, 2) != 0);
      samp_in  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else begin
         out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      e_ir = 0; e_we = 0; e_wsel = 1; e_waddr = 0; e_iss = 0; e_en = 0; e_clr = 0; k = 0;
      if (init_idx < N_TAPS) begin
         e_we    = 1;
         e_waddr = init_idx;
      end else if (busy == 0) begin
         e_ir = 1;
         if (in_valid) begin
            e_we    = 1;
            e_wsel  = 0;
            e_waddr = wp_m;
         end
      end else begin
         e_iss = (d <= N_TAPS);
         k     = d - 1;
         e_en  = (d - RD_LAT >= 1) && (d - RD_LAT <= N_TAPS);
         e_clr = (d == 1 + RD_LAT);
      end
      chk("in_ready",  32'(in_ready),  32'(e_ir));
      chk("samp_we",   32'(samp_we),   32'(e_we));
      chk("acc_en",    32'(acc_en),    32'(e_en));
      chk("acc_clr",   32'(acc_clr),   32'(e_clr));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      if (e_we) begin
         chk("samp_waddr", 32'(samp_waddr), 32'(e_waddr));
         chk("samp_wsel",  32'(samp_wsel),  32'(e_wsel));
      end
      if (e_iss) begin
         chk("samp_raddr", 32'(samp_raddr), 32'((base_m - k + N_TAPS) % N_TAPS));
         chk("coef_raddr", 32'(coef_raddr), 32'(k));
      end

      if (init_idx < N_TAPS) begin
         init_idx++;
      end else if (busy == 0) begin
         if (in_valid) begin
            busy    = 1;
            acc_cyc = cyc;
            base_m  = wp_m;
            hist.push_front(int'(samp_in));
            if (hist.size() > N_TAPS) void'(hist.pop_back());
            y = '0;
            for (int i = 0; i < hist.size(); i++) y += 32'(hist[i]) * rom[i];
            exp_q.push_back(y);
         end
      end else if (e_ov && out_ready) begin
         chk("exp_q_size", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) chk("y", acc_m, exp_q.pop_front());
         busy = 0;
         wp_m = (wp_m + 1) % N_TAPS;
         n_out++;
      end
      cyc++;
      guard++;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d got=hang exp=finish", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++)
         rom[i] = (i < N_TAPS) ? 32'($urandom_range(1, 255)) : 32'd0;
      n_out      = 0;
      stall_done = 0;
      model_reset();
      do_reset();

      while (n_out < N_OUT_A && guard < GUARD) step();

      // Abort an accumulation partway through the tap loop.
      while (!(busy != 0 && (cyc - acc_cyc) == 3) && guard < GUARD) step();
      do_reset();

      while (n_out < N_OUT_B && guard < GUARD) step();
      chk("n_out", 32'(n_out), 32'(N_OUT_B));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer for a time-multiplexed (single-MAC) FIR: one multiplier/accumulator shared across all taps instead of N_TAPS parallel multipliers.
- Owns the circular sample-RAM write pointer, the tap loop, the sample/coefficient read addresses, accumulator control and the output handshake.
- Sits between the sample source and the fir datapath (sample RAM, coefficient ROM, MAC); the datapath holds all data, this block holds no sample data.

Parameters:
- WIDTH, 10, sample width; passed through to the datapath, unused internally.
- N_TAPS, 465, number of taps; also the sample-buffer depth.
- ADDR_W, 9, address width; must satisfy 2**ADDR_W >= N_TAPS.
- RD_LAT, 1, cycles from read address to product valid at the MAC input (1..4).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  new sample present on the datapath input.
- in_ready  out  1  controller accepts a sample this cycle.
- samp_we  out  1  sample-RAM write enable.
- samp_wsel  out  1  write-data select: 0 = input sample, 1 = zero.
- samp_waddr  out  ADDR_W  sample-RAM write address.
- samp_raddr  out  ADDR_W  sample-RAM read address.
- coef_raddr  out  ADDR_W  coefficient-ROM read address.
- acc_clr  out  1  MAC loads the product instead of adding it.
- acc_en  out  1  MAC update enable.
- out_valid  out  1  accumulator holds a finished output.
- out_ready  in  1  consumer takes the output.

Behaviour:
- Reset (async assert, sync release): state=INIT, wp=0, k=0, all outputs 0; samp_wsel=1.
- States:
  - INIT: samp_we=1, samp_wsel=1, samp_waddr=init counter 0..N_TAPS-1, one address per cycle, zero-filling the buffer. Lasts N_TAPS cycles, then IDLE.
  - IDLE: in_ready=1. On in_valid: samp_we=1, samp_wsel=0, samp_waddr=wp (combinational with the accept); latch base=wp; go RUN.
  - RUN: k runs 0..N_TAPS-1, one tap per cycle.
    - coef_raddr=k.
    - samp_raddr=(base-k) mod N_TAPS, produced by a down-counter that wraps 0 -> N_TAPS-1 (no modulo operator).
    - After the k=N_TAPS-1 issue, go DRAIN.
  - DRAIN: RD_LAT cycles, then DONE.
  - DONE: out_valid=1, held until out_ready=1. In that cycle: wp <= (wp==N_TAPS-1) ? 0 : wp+1; go IDLE.
- acc_en is the RUN-issue strobe delayed by RD_LAT; acc_clr is asserted with the first acc_en of each output only.
- Timing with accept at cycle A:
  - Issues at A+1..A+N_TAPS.
  - acc_en at A+1+RD_LAT..A+N_TAPS+RD_LAT.
  - out_valid rises at A+N_TAPS+RD_LAT+1.
  - Defaults (465 taps, RD_LAT=1): out_valid at A+467.
- in_ready=0 in INIT, RUN, DRAIN and DONE. in_valid in those states is ignored and not stored; the source must hold it.
- Minimum sample period: N_TAPS+RD_LAT+2 cycles (out_ready tied high).
- out_ready while out_valid=0: ignored.
- samp_we is never asserted outside INIT and the IDLE-accept cycle. The sample read at base (k=0) is the sample just written, so the RAM must be read-after-write or the write must commit before A+1.
- Reset asserted mid-RUN or mid-DONE: immediate return to INIT; partial output discarded; buffer re-zeroed.
- N_TAPS=1: RUN lasts one cycle; samp_raddr=base; wp stays 0.

Test Plan:
- Reset then idle, N_TAPS=4 -> samp_we high 4 cycles, samp_waddr 0,1,2,3, samp_wsel=1; in_ready rises the cycle after.
- N_TAPS=4, RD_LAT=1, accept at cycle A, wp=2 -> samp_raddr 2,1,0,3 and coef_raddr 0,1,2,3 at A+1..A+4; acc_clr only at A+2; out_valid at A+6.
- out_ready held low 10 cycles after out_valid -> out_valid stays 1, in_ready stays 0, wp unchanged; release -> wp advances once, in_ready=1 next cycle.
- Defaults: 5 back-to-back samples with out_ready=1 -> accepts exactly 468 cycles apart; wp sequence 0..4; datapath with all-ones coefficients and constant input 200 yields outputs 200,400,600,800,1000.
- wp at N_TAPS-1 when a sample is accepted -> next wp=0; following output's samp_raddr sequence starts at 0 then N_TAPS-1.
- reset_n pulsed low mid-RUN (k=100) -> all outputs 0 asynchronously, no out_valid; full INIT sweep after release.
